// File: rtl/washing_machine_multi.sv
// washing_machine_multi
//   Parametrised washer controller. A coin in IDLE starts 1..MAX_WASHES
//   fill/wash/rinse loops followed by a single spin, then a one-cycle DONE.
//   Each phase is timed in whole seconds derived from a CLK_HZ prescaler.
//
// Ports
//   CLK          in   system clock, rising edge
//   rst          in   synchronous active-high reset (highest priority)
//   coin_in      in   start request, sampled only in IDLE
//   wash_count   in   requested loop count, sampled when a coin is accepted
//   timer_pause  in   freezes the phase timer, effective only in SPIN
//   abort        in   cancel the run, return to IDLE without wash_done
//   wash_done    out  one-cycle completion pulse (high only in DONE)
//   state_op     out  phase: IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5
//   sec_flag_op  out  whole seconds elapsed in the current phase
//   washes_left  out  loops remaining, including the one in progress
module washing_machine_multi #(
  parameter  int CLK_HZ     = 50_000_000,
  parameter  int FILL_SEC   = 120,
  parameter  int WASH_SEC   = 300,
  parameter  int RINSE_SEC  = 120,
  parameter  int SPIN_SEC   = 60,
  parameter  int MAX_WASHES = 3,
  parameter  int SEC_W      = 9,
  localparam int CNT_W      = $clog2(MAX_WASHES + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             coin_in,
  input  logic [CNT_W-1:0] wash_count,
  input  logic             timer_pause,
  input  logic             abort,
  output logic             wash_done,
  output logic [2:0]       state_op,
  output logic [SEC_W-1:0] sec_flag_op,
  output logic [CNT_W-1:0] washes_left
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [PRE_W-1:0] presc, presc_next;
  logic [SEC_W-1:0] sec,   sec_next;
  logic [CNT_W-1:0] washes, washes_next;
  logic             done_q, done_next;

  logic             spin_hold;
  logic             tick;
  logic             phase_last;
  logic [CNT_W-1:0] count_eff;

  // State register: every piece of state, including the done pulse, is
  // captured here so all outputs come straight from flops.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= S_IDLE;
      presc  <= '0;
      sec    <= '0;
      washes <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      presc  <= presc_next;
      sec    <= sec_next;
      washes <= washes_next;
      done_q <= done_next;
    end
  end

  // Requested loop count clamped into 1..MAX_WASHES.
  always_comb begin
    count_eff = wash_count;
    if (wash_count == '0)
      count_eff = CNT_W'(1);
    else if (int'(wash_count) > MAX_WASHES)
      count_eff = CNT_W'(MAX_WASHES);
  end

  // Next-state and timer logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    presc_next  = presc;
    sec_next    = sec;
    washes_next = washes;

    // A paused SPIN freezes the prescaler, which also suppresses its tick.
    spin_hold = (state == S_SPIN) && timer_pause;
    tick      = (presc == PRE_MAX) && !spin_hold;

    unique case (state)
      S_FILL:  phase_last = (sec == SEC_W'(FILL_SEC - 1));
      S_WASH:  phase_last = (sec == SEC_W'(WASH_SEC - 1));
      S_RINSE: phase_last = (sec == SEC_W'(RINSE_SEC - 1));
      S_SPIN:  phase_last = (sec == SEC_W'(SPIN_SEC - 1));
      default: phase_last = 1'b0;
    endcase

    if (state inside {S_FILL, S_WASH, S_RINSE, S_SPIN} && !spin_hold) begin
      presc_next = tick ? '0 : presc + PRE_W'(1);
      sec_next   = tick ? sec + SEC_W'(1) : sec;
    end

    if (abort) begin
      // In IDLE this only blocks the coin; elsewhere it cancels the run.
      state_next  = S_IDLE;
      washes_next = '0;
    end else begin
      unique case (state)
        S_IDLE: if (coin_in) begin
          state_next  = S_FILL;
          washes_next = count_eff;
        end
        S_FILL:  if (tick && phase_last) state_next = S_WASH;
        S_WASH:  if (tick && phase_last) state_next = S_RINSE;
        S_RINSE: if (tick && phase_last) begin
          if (washes > CNT_W'(1)) begin
            state_next  = S_FILL;
            washes_next = washes - CNT_W'(1);
          end else begin
            state_next = S_SPIN;
          end
        end
        S_SPIN: if (tick && phase_last) begin
          state_next  = S_DONE;
          washes_next = '0;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end

    // Any phase change restarts the phase timer from zero.
    if (state_next != state) begin
      presc_next = '0;
      sec_next   = '0;
    end

    done_next = (state_next == S_DONE);
  end

  // Output logic: direct views of the registered state.
  always_comb begin
    state_op    = state;
    sec_flag_op = sec;
    washes_left = washes;
    wash_done   = done_q;
  end

endmodule

// File: tb/tb_washing_machine_multi.sv
// Self-checking bench for washing_machine_multi with small timing parameters.
// Expected outputs come from a phase-timeline model: the number of unpaused
// cycles since the coin is mapped arithmetically onto loop/phase/second.
module tb_washing_machine_multi;

  localparam int C = 4;   // CLK_HZ
  localparam int F = 1;   // FILL_SEC
  localparam int W = 2;   // WASH_SEC
  localparam int R = 1;   // RINSE_SEC
  localparam int S = 2;   // SPIN_SEC
  localparam int M = 3;   // MAX_WASHES
  localparam int SEC_W = 9;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             rst;
  logic             coin_in;
  logic [CNT_W-1:0] wash_count;
  logic             timer_pause;
  logic             abort;
  logic             wash_done;
  logic [2:0]       state_op;
  logic [SEC_W-1:0] sec_flag_op;
  logic [CNT_W-1:0] washes_left;

  int total = 0;
  int bad   = 0;

  washing_machine_multi #(
    .CLK_HZ(C), .FILL_SEC(F), .WASH_SEC(W), .RINSE_SEC(R),
    .SPIN_SEC(S), .MAX_WASHES(M), .SEC_W(SEC_W)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .coin_in    (coin_in),
    .wash_count (wash_count),
    .timer_pause(timer_pause),
    .abort      (abort),
    .wash_done  (wash_done),
    .state_op   (state_op),
    .sec_flag_op(sec_flag_op),
    .washes_left(washes_left)
  );

  always #5 CLK = ~CLK;

  function automatic int clamp_count(input int n);
    if (n == 0) return 1;
    if (n > M)  return M;
    return n;
  endfunction

  // Expected outputs after `a` active (unpaused) cycles of a run of n loops.
  function automatic void model(input int a, input int n, output int ph,
                                output int sec, output int left, output bit done);
    int loop_len, r, spin_start;
    loop_len   = (F + W + R) * C;
    spin_start = n * loop_len;
    done = 1'b0;
    if (a < spin_start) begin
      r    = a % loop_len;
      left = n - a / loop_len;
      if (r < F * C) begin
        ph = 1; sec = r / C;
      end else if (r < (F + W) * C) begin
        ph = 2; sec = (r - F * C) / C;
      end else begin
        ph = 3; sec = (r - (F + W) * C) / C;
      end
    end else if (a < spin_start + S * C) begin
      ph = 4; sec = (a - spin_start) / C; left = 1;
    end else if (a == spin_start + S * C) begin
      ph = 5; sec = 0; left = 0; done = 1'b1;
    end else begin
      ph = 0; sec = 0; left = 0;
    end
  endfunction

  // Drives one run from IDLE and checks every cycle against the model.
  //   pause_mode: 0 none, 1 random in every phase, 2 first 10 SPIN cycles
  //   abort_at / rst_at: cycle index (edges after coin) to cancel, -1 = never
  //   dut_done: edge index at which the DUT showed wash_done, -1 = never
  task automatic run(input int n_req, input int pause_mode, input bit wc_change,
                     input bit coin_busy, input int abort_at, input int rst_at,
                     input bit hold_coin, output int dut_done);
    int n, a, paused, iter, ph, sec, left;
    bit done, fin;
    n = clamp_count(n_req);
    coin_in    = 1'b1;
    wash_count = CNT_W'(n_req);
    @(negedge CLK);
    a = 0; paused = 0; iter = 0; fin = 1'b0; dut_done = -1;
    coin_in = hold_coin;
    while (!fin && iter < 400) begin
      model(a, n, ph, sec, left, done);
      total++;
      if (state_op !== 3'(ph)) begin
        bad++; $display("FAIL run_state n=%0d cyc=%0d got=%0d exp=%0d", n_req, iter, state_op, ph);
      end
      total++;
      if (sec_flag_op !== SEC_W'(sec)) begin
        bad++; $display("FAIL run_sec n=%0d cyc=%0d got=%0d exp=%0d", n_req, iter, sec_flag_op, sec);
      end
      total++;
      if (washes_left !== CNT_W'(left)) begin
        bad++; $display("FAIL run_left n=%0d cyc=%0d got=%0d exp=%0d", n_req, iter, washes_left, left);
      end
      total++;
      if (wash_done !== done) begin
        bad++; $display("FAIL run_done n=%0d cyc=%0d got=%0d exp=%0d", n_req, iter, wash_done, done);
      end
      if (wash_done === 1'b1 && dut_done < 0) dut_done = iter;

      if (ph == 0) begin
        fin = 1'b1;
      end else if (iter == abort_at) begin
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        total++;
        if (state_op !== 3'd0 || washes_left !== '0 || sec_flag_op !== '0 || wash_done !== 1'b0) begin
          bad++; $display("FAIL abort_idle got st=%0d left=%0d sec=%0d done=%0d exp all 0",
                          state_op, washes_left, sec_flag_op, wash_done);
        end
        fin = 1'b1;
      end else if (iter == rst_at) begin
        rst = 1'b1; coin_in = 1'b1;
        @(negedge CLK);
        total++;
        if (state_op !== 3'd0 || washes_left !== '0 || sec_flag_op !== '0 || wash_done !== 1'b0) begin
          bad++; $display("FAIL rst_mid got st=%0d left=%0d sec=%0d done=%0d exp all 0",
                          state_op, washes_left, sec_flag_op, wash_done);
        end
        @(negedge CLK);
        total++;
        if (state_op !== 3'd0) begin
          bad++; $display("FAIL rst_coin_ignored got=%0d exp=0", state_op);
        end
        rst = 1'b0; coin_in = 1'b0;
        @(negedge CLK);
        total++;
        if (state_op !== 3'd0) begin
          bad++; $display("FAIL rst_release_idle got=%0d exp=0", state_op);
        end
        fin = 1'b1;
      end else begin
        case (pause_mode)
          1:       timer_pause = ($urandom_range(0, 2) == 0);
          2:       timer_pause = (ph == 4) && (paused < 10);
          default: timer_pause = 1'b0;
        endcase
        if (coin_busy) coin_in = hold_coin | $urandom_range(0, 1);
        if (wc_change) wash_count = CNT_W'($urandom);
        if (ph == 4 && timer_pause) paused++;
        else                        a++;
        @(negedge CLK);
        iter++;
      end
    end
    timer_pause = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout n=%0d cycles=%0d", n_req, iter);
      rst = 1'b1; @(negedge CLK); rst = 1'b0;
    end
    if (abort_at < 0 && rst_at < 0) begin
      total++;
      if (dut_done != C * (n * (F + W + R) + S) + paused) begin
        bad++; $display("FAIL run_done_edge n=%0d got=%0d exp=%0d", n_req, dut_done,
                        C * (n * (F + W + R) + S) + paused);
      end
    end
    if (hold_coin && fin && abort_at < 0 && rst_at < 0) begin
      // Coin still high in IDLE: a new run must start on the next edge.
      wash_count = CNT_W'(n_req);
      @(negedge CLK);
      total++;
      if (state_op !== 3'd1 || washes_left !== CNT_W'(n)) begin
        bad++; $display("FAIL b2b_restart got st=%0d left=%0d exp st=1 left=%0d", state_op, washes_left, n);
      end
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
    end
    coin_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; coin_in = 1'b1; wash_count = 2'd2; timer_pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (state_op !== 3'd0 || sec_flag_op !== '0 || washes_left !== '0 || wash_done !== 1'b0) begin
      bad++; $display("FAIL reset_state got st=%0d sec=%0d left=%0d done=%0d exp all 0",
                      state_op, sec_flag_op, washes_left, wash_done);
    end
    rst = 1'b0; coin_in = 1'b0;
    @(negedge CLK);
    total++;
    if (state_op !== 3'd0) begin
      bad++; $display("FAIL reset_idle got=%0d exp=0", state_op);
    end
  endtask

  task automatic test_single();
    int d;
    run(1, 0, 1'b0, 1'b0, -1, -1, 1'b0, d);
    total++;
    if (d != 24) begin bad++; $display("FAIL single_done_edge got=%0d exp=24", d); end
  endtask

  task automatic test_triple();
    int d;
    run(3, 0, 1'b0, 1'b0, -1, -1, 1'b0, d);
    total++;
    if (d != 56) begin bad++; $display("FAIL triple_done_edge got=%0d exp=56", d); end
  endtask

  task automatic test_clamp();
    int d;
    run(0, 0, 1'b1, 1'b0, -1, -1, 1'b0, d);
    total++;
    if (d != 24) begin bad++; $display("FAIL clamp_zero_done got=%0d exp=24", d); end
    for (int i = 0; i < 4; i++)
      run($urandom_range(0, 3), 1, 1'b1, 1'b1, -1, -1, 1'b0, d);
  endtask

  task automatic test_pause();
    int d;
    run(1, 2, 1'b0, 1'b0, -1, -1, 1'b0, d);
    total++;
    if (d != 34) begin bad++; $display("FAIL pause_done_edge got=%0d exp=34", d); end
    run(2, 1, 1'b0, 1'b0, -1, -1, 1'b0, d);
  endtask

  task automatic test_abort();
    int d;
    run(1, 0, 1'b0, 1'b0, 8, -1, 1'b0, d);
    total++;
    if (d != -1) begin bad++; $display("FAIL abort_no_done got=%0d exp=-1", d); end
    run(2, 0, 1'b0, 1'b0, -1, -1, 1'b0, d);
    // Abort on the last SPIN cycle must not produce DONE.
    run(1, 0, 1'b0, 1'b0, 23, -1, 1'b0, d);
    total++;
    if (d != -1) begin bad++; $display("FAIL abort_final_tick got=%0d exp=-1", d); end
    // Abort in IDLE blocks a coin for that cycle.
    coin_in = 1'b1; abort = 1'b1;
    @(negedge CLK);
    coin_in = 1'b0; abort = 1'b0;
    total++;
    if (state_op !== 3'd0) begin bad++; $display("FAIL abort_blocks_coin got=%0d exp=0", state_op); end
  endtask

  task automatic test_reset_mid();
    int d;
    run(2, 0, 1'b0, 1'b1, -1, 13, 1'b0, d);
    run(1, 0, 1'b0, 1'b1, -1, -1, 1'b0, d);
  endtask

  task automatic test_back_to_back();
    int d;
    run(1, 0, 1'b0, 1'b1, -1, -1, 1'b1, d);
  endtask

  initial begin
    test_reset();
    test_single();
    test_triple();
    test_clamp();
    test_pause();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/washing_machine_multi.md
# washing_machine_multi

Parametrised washing-machine controller, successor to the fixed two-mode washer. It adds compile-time clock rate and phase durations, a run-time wash/rinse repeat count of 1..MAX_WASHES, a spin-only pause, and an abort input. It sits between the coin/panel inputs and the motor/valve drivers. It exposes the current phase, the elapsed seconds in that phase, and the remaining wash count.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clock cycles per second. Must be at least 2.
- FILL_SEC, 120: fill phase length in seconds. Must be at least 1.
- WASH_SEC, 300: wash phase length in seconds. Must be at least 1.
- RINSE_SEC, 120: rinse phase length in seconds. Must be at least 1.
- SPIN_SEC, 60: spin phase length in seconds. Must be at least 1.
- MAX_WASHES, 3: maximum number of fill/wash/rinse loops.
- SEC_W, 9: seconds-counter width. Every *_SEC must be at most 2^SEC_W−1.
- CNT_W (localparam): clog2(MAX_WASHES+1).

Ports:
- CLK  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_in  in  1  start request. Sampled only in IDLE.
- wash_count  in  CNT_W  number of loops requested. Sampled only when a coin is accepted.
- timer_pause  in  1  freezes the timer. Effective only in SPIN.
- abort  in  1  cancels the run and returns to IDLE.
- wash_done  out  1  one-cycle completion pulse.
- state_op  out  3  current phase: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
- sec_flag_op  out  SEC_W  whole seconds elapsed in the current phase.
- washes_left  out  CNT_W  loops remaining, counting the one in progress.

## Operation
- Reset:
  - state_op=0, sec_flag_op=0, washes_left=0, wash_done=0.
  - The prescaler is also cleared.
  - rst has priority over every other input.
- Priority order: rst, then abort, then phase logic.
- IDLE:
  - On coin_in=1 the next state is FILL.
  - washes_left is loaded with wash_count. A value of 0 is loaded as 1; a value above MAX_WASHES is loaded as MAX_WASHES.
- Phase timer:
  - The prescaler counts 0..CLK_HZ−1 and then wraps to 0.
  - The cycle where the prescaler equals CLK_HZ−1 is the second tick.
  - Each tick increments sec_flag_op.
- Phase end and next state:
  - A phase ends on a tick where sec_flag_op equals its *_SEC−1.
  - FILL goes to WASH.
  - WASH goes to RINSE.
  - RINSE goes to FILL when washes_left>1, decrementing washes_left. Otherwise it goes to SPIN.
  - SPIN goes to DONE, and washes_left is set to 0.
- On every state change, the prescaler and sec_flag_op are cleared to 0.
- DONE: lasts exactly one cycle with wash_done=1, then goes to IDLE. wash_done is 0 in every other state.
- timer_pause:
  - In SPIN, timer_pause=1 holds the prescaler and sec_flag_op. state_op stays 4.
  - In all other states timer_pause is ignored.
- abort:
  - In any state other than IDLE, abort=1 sends the block to IDLE on the next edge.
  - It clears washes_left, sec_flag_op and the prescaler.
  - wash_done is not pulsed.
  - In IDLE, abort=1 blocks coin acceptance for that cycle.
- coin_in while busy is ignored, and so is a change of wash_count while busy.

## Timing
- All outputs are registered. state_op changes on the edge after the triggering input is sampled.
- Each phase lasts exactly *_SEC × CLK_HZ cycles, plus the number of paused cycles for SPIN.
- Suppose a coin is sampled at edge k with effective count N:
  - FILL starts at k.
  - DONE is entered at k + CLK_HZ × (N × (FILL_SEC+WASH_SEC+RINSE_SEC) + SPIN_SEC).
  - IDLE is entered one edge after DONE.
- A coin held high continuously restarts a run one cycle after DONE, since the block is back in IDLE.
- Pause asserted on the same edge as a SPIN tick: the tick is suppressed.
- Abort on the final tick of SPIN: the block goes to IDLE and no DONE/wash_done is produced.
- Reset mid-phase: all outputs are at reset values after the next edge.

## Test plan
All scenarios use CLK_HZ=4, FILL_SEC=1, WASH_SEC=2, RINSE_SEC=1, SPIN_SEC=2, MAX_WASHES=3.
- Single wash (wash_count=1, coin pulse at edge 0):
  - state_op sequence 1 / 2 / 3 / 4, entered at edges 0 / 4 / 12 / 16.
  - DONE at edge 24 with wash_done=1 for one cycle; IDLE at edge 25.
  - sec_flag_op increments every 4 cycles.
- Triple wash (wash_count=3):
  - Three FILL→WASH→RINSE loops, with washes_left stepping 3 → 2 → 1.
  - DONE at edge 56. washes_left=0 in DONE.
- Clamp cases:
  - wash_count=0 behaves as 1, with DONE at 24.
  - A change of wash_count mid-run has no effect.
- Spin pause:
  - Hold timer_pause for 10 cycles during SPIN: DONE moves from 24 to 34.
  - sec_flag_op is frozen while paused.
  - A pause during WASH changes nothing.
- Abort:
  - abort at edge 8 (in WASH) gives IDLE at edge 9, washes_left=0, and no wash_done.
  - A coin at edge 10 starts a fresh run.
- Reset mid-run:
  - rst=1 during RINSE gives all outputs 0 next edge.
  - A coin during rst is ignored.
  - Coins during a run do not restart it.
